cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cmp_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// Two-requester arbiter that time-shares one external compare unit (IDLE -> ISSUE -> RESP).
// Define CMP_ARB_RR_EN for round-robin tie-breaking; otherwise r0 has fixed priority.
module cmp_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           r0_valid,
    input  logic [DW-1:0]  r0_a,
    input  logic [DW-1:0]  r0_b,
    input  logic [OPW-1:0] r0_op,
    output logic           r0_ready,
    output logic           r0_rsp_valid,
    input  logic           r0_rsp_ready,
    output logic [DW-1:0]  r0_result,
    output logic           r0_flag,

    input  logic           r1_valid,
    input  logic [DW-1:0]  r1_a,
    input  logic [DW-1:0]  r1_b,
    input  logic [OPW-1:0] r1_op,
    output logic           r1_ready,
    output logic           r1_rsp_valid,
    input  logic           r1_rsp_ready,
    output logic [DW-1:0]  r1_result,
    output logic           r1_flag,

    output logic [DW-1:0]  cmp_a,
    output logic [DW-1:0]  cmp_b,
    output logic [OPW-1:0] cmp_op,
    input  logic [DW-1:0]  cmp_result,
    input  logic           cmp_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           id_q, id_d;
    logic [DW-1:0]  r0_res_q, r0_res_d;
    logic [DW-1:0]  r1_res_q, r1_res_d;
    logic           r0_flg_q, r0_flg_d;
    logic           r1_flg_q, r1_flg_d;
    logic           any_valid;
    logic           sel_r1;
    logic           owner_rsp_ready;

    assign any_valid       = r0_valid | r1_valid;
    assign owner_rsp_ready = id_q ? r1_rsp_ready : r0_rsp_ready;

`ifdef CMP_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On a tie the requester that did not win last time gets the grant.
    assign sel_r1 = r1_valid & (~r0_valid | ~last_grant_q);
`else
    assign sel_r1 = r1_valid & ~r0_valid;
`endif

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        r0_res_d     = r0_res_q;
        r1_res_d     = r1_res_q;
        r0_flg_d     = r0_flg_q;
        r1_flg_d     = r1_flg_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
`ifdef CMP_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    r0_ready = ~sel_r1;
                    r1_ready = sel_r1;
                    a_d      = sel_r1 ? r1_a  : r0_a;
                    b_d      = sel_r1 ? r1_b  : r0_b;
                    op_d     = sel_r1 ? r1_op : r0_op;
                    id_d     = sel_r1;
                    state_d  = ISSUE;
`ifdef CMP_ARB_RR_EN
                    last_grant_d = sel_r1;
`endif
                end
            end
            ISSUE: begin
                // Compare unit is combinational; its answer is taken in this single cycle.
                if (id_q) begin
                    r1_res_d = cmp_result;
                    r1_flg_d = cmp_flag;
                end else begin
                    r0_res_d = cmp_result;
                    r0_flg_d = cmp_flag;
                end
                state_d = RESP;
            end
            RESP: begin
                r0_rsp_valid = ~id_q;
                r1_rsp_valid = id_q;
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            r0_res_q <= '0;
            r1_res_q <= '0;
            r0_flg_q <= 1'b0;
            r1_flg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            r0_res_q <= r0_res_d;
            r1_res_q <= r1_res_d;
            r0_flg_q <= r0_flg_d;
            r1_flg_q <= r1_flg_d;
        end
    end

`ifdef CMP_ARB_RR_EN
    // Reset to 1 so that r0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign cmp_a     = a_q;
    assign cmp_b     = b_q;
    assign cmp_op    = op_q;
    assign r0_result = r0_res_q;
    assign r0_flag   = r0_flg_q;
    assign r1_result = r1_res_q;
    assign r1_flag   = r1_flg_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed scoreboard bench for cmp_arbiter with a small behavioural compare unit attached.
module tb_cmp_arbiter;
    localparam int DW  = 32;
    localparam int OPW = 5;
`ifdef CMP_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_flag;
    logic [DW-1:0]  r0_a, r0_b, r0_result;
    logic [OPW-1:0] r0_op;
    logic           r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_flag;
    logic [DW-1:0]  r1_a, r1_b, r1_result;
    logic [OPW-1:0] r1_op;
    logic [DW-1:0]  cmp_a, cmp_b, cmp_result;
    logic [OPW-1:0] cmp_op;
    logic           cmp_flag;

    typedef struct {
        logic          id;
        logic [DW-1:0] res;
        logic          flg;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    cmp_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_ready(r0_ready),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result), .r0_flag(r0_flag),
        .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_ready(r1_ready),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result), .r1_flag(r1_flag),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_result(cmp_result), .cmp_flag(cmp_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural compare unit: 14 maxu, 15 minu, 17 eq, 18 sub; anything else returns zero.
    function automatic logic [DW-1:0] cu_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OPW-1:0] op);
        case (op)
            5'd14:   return (a > b) ? a : b;
            5'd15:   return (a < b) ? a : b;
            5'd17:   return {{(DW-1){1'b0}}, (a == b)};
            5'd18:   return a - b;
            default: return '0;
        endcase
    endfunction

    function automatic logic cu_flg(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [OPW-1:0] op);
        case (op)
            5'd14:   return a > b;
            5'd15:   return a < b;
            5'd17:   return a == b;
            5'd18:   return a < b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        cmp_result = cu_res(cmp_a, cmp_b, cmp_op);
        cmp_flag   = cu_flg(cmp_a, cmp_b, cmp_op);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ready(input logic e0, input logic e1);
        chk("r0_ready", r0_ready, e0);
        chk("r1_ready", r1_ready, e1);
    endtask

    task automatic push(input logic id, input logic [DW-1:0] res, input logic flg);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.flg = flg;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic expect_rsp();
        exp_t e;
        chk("sb_level", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("r0_rsp_valid", r0_rsp_valid, (e.id == 1'b0));
            chk("r1_rsp_valid", r1_rsp_valid, (e.id == 1'b1));
            chk("rsp_result", e.id ? r1_result : r0_result, e.res);
            chk("rsp_flag", e.id ? r1_flag : r0_flag, e.flg);
            chk("rsp_latency", cyc - e.cyc, 2);
        end
    endtask

    task automatic chk_cleared();
        chk("rst_r0_rsp_valid", r0_rsp_valid, 0);
        chk("rst_r1_rsp_valid", r1_rsp_valid, 0);
        chk("rst_cmp_a", cmp_a, 0);
        chk("rst_cmp_b", cmp_b, 0);
        chk("rst_cmp_op", cmp_op, 0);
    endtask

    initial begin
        logic exp_id;
        rst = 1'b1;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0; r0_rsp_ready = 1'b0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0; r1_rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_cleared();
        chk("rst_r0_result", r0_result, 0);
        chk("rst_r1_result", r1_result, 0);
        chk("rst_r0_flag", r0_flag, 0);
        chk("rst_r1_flag", r1_flag, 0);
        rst = 1'b0;

        // r0 equality compare, 5 == 5
        @(negedge clk); r0_valid = 1'b1; r0_a = 5; r0_b = 5; r0_op = 17; #1;
        chk_ready(1'b1, 1'b0);
        push(1'b0, 1, 1'b1);
        @(negedge clk); r0_valid = 1'b0; #1;
        chk_ready(1'b0, 1'b0);
        chk("issue_cmp_a", cmp_a, 5);
        chk("issue_cmp_b", cmp_b, 5);
        chk("issue_cmp_op", cmp_op, 17);
        @(negedge clk); #1;
        expect_rsp();
        r0_rsp_ready = 1'b1;
        @(negedge clk); r0_rsp_ready = 1'b0; #1;
        chk("r0_rsp_done", r0_rsp_valid, 0);
        chk("hold_cmp_op", cmp_op, 17);

        // r1 minu with a stalled consumer; r0 waits meanwhile
        @(negedge clk); r1_valid = 1'b1; r1_a = 32'h1234; r1_b = 7; r1_op = 15; #1;
        chk_ready(1'b0, 1'b1);
        push(1'b1, 7, 1'b0);
        @(negedge clk); r1_valid = 1'b0; r0_valid = 1'b1; r0_a = 3; r0_b = 3; r0_op = 9; #1;
        chk_ready(1'b0, 1'b0);
        @(negedge clk); #1;
        expect_rsp();
        chk_ready(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("stall_r1_rsp_valid", r1_rsp_valid, 1);
            chk("stall_r1_result", r1_result, 7);
            chk("stall_r1_flag", r1_flag, 0);
            chk_ready(1'b0, 1'b0);
        end
        r1_rsp_ready = 1'b1;

        // Back in IDLE: unknown opcode from r0
        @(negedge clk); r1_rsp_ready = 1'b0; #1;
        chk("r1_rsp_done", r1_rsp_valid, 0);
        chk_ready(1'b1, 1'b0);
        push(1'b0, 0, 1'b0);
        @(negedge clk); r0_valid = 1'b0; #1;
        chk_ready(1'b0, 1'b0);
        chk("issue_unknown_op", cmp_op, 9);
        @(negedge clk); r1_rsp_ready = 1'b1; #1;
        expect_rsp();
        @(negedge clk); r1_rsp_ready = 1'b0; #1;
        chk("foreign_rdy_r0_valid", r0_rsp_valid, 1);
        chk("foreign_rdy_r0_result", r0_result, 0);
        chk("foreign_rdy_r1_valid", r1_rsp_valid, 0);
        r0_rsp_ready = 1'b1;
        @(negedge clk); r0_rsp_ready = 1'b0; #1;
        chk("r0_rsp_done2", r0_rsp_valid, 0);

        // Reset while ISSUE is in flight
        @(negedge clk); r1_valid = 1'b1; r1_a = 32'h55; r1_b = 32'h66; r1_op = 18; #1;
        chk_ready(1'b0, 1'b1);
        @(negedge clk); r1_valid = 1'b0; rst = 1'b1; #1;
        chk("inflight_cmp_a", cmp_a, 32'h55);
        @(negedge clk); rst = 1'b0;
        r0_valid = 1'b1; r0_a = 10; r0_b = 3; r0_op = 18;
        r1_valid = 1'b1; r1_a = 4;  r1_b = 9; r1_op = 14;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        #1;
        chk_cleared();

        // Continuous tie: alternating grants with round-robin, r0 only otherwise
        for (int g = 0; g < 4; g++) begin
            if (g != 0) begin
                @(negedge clk); #1;
            end
            exp_id = RR ? g[0] : 1'b0;
            chk_ready(~exp_id, exp_id);
            if (exp_id) push(1'b1, cu_res(4, 9, 14), cu_flg(4, 9, 14));
            else        push(1'b0, cu_res(10, 3, 18), cu_flg(10, 3, 18));
            @(negedge clk); #1;
            chk_ready(1'b0, 1'b0);
            @(negedge clk); #1;
            expect_rsp();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk); r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0; #1;
        chk_ready(1'b0, 1'b0);
        chk("final_r0_rsp_valid", r0_rsp_valid, 0);
        chk("final_r1_rsp_valid", r1_rsp_valid, 0);
        chk("final_hold_cmp_op", cmp_op, RR ? 14 : 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
